// File: rtl/itc_mode_bank.sv
// itc_mode_bank: video mode register bank with header matching and frame-synchronous timing shadow.
// Define ITC_MODE_READBACK_EN to enable the combinational register readback on mb_readdata.
module itc_mode_bank #(
    parameter int NO_OF_MODES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_trigger,
    input  logic [7:0]             av_address,
    input  logic [15:0]            av_writedata,
    output logic                   av_write_ack,
    input  logic                   hdr_valid,
    input  logic [15:0]            hdr_width,
    input  logic [15:0]            hdr_height,
    input  logic                   hdr_interlaced,
    input  logic                   frame_start,
    output logic [NO_OF_MODES-1:0] mode_match,
    output logic                   mode_change,
    output logic                   cur_valid,
    output logic                   cur_interlaced,
    output logic [15:0]            cur_width,
    output logic [15:0]            cur_height,
    output logic [15:0]            cur_h_blank,
    output logic [15:0]            cur_v_blank,
    output logic [15:0]            cur_h_sync,
    output logic [15:0]            cur_v_sync,
    output logic [15:0]            mb_readdata
);
    localparam int IW = (NO_OF_MODES > 1) ? $clog2(NO_OF_MODES) : 1;
    typedef enum logic {W_IDLE, W_ACK} wstate_t;
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} sstate_t;
    typedef struct packed {
        logic        valid;
        logic        intl;
        logic [15:0] w, h, hb, vb, hs, vs;
    } timing_t;

    logic [NO_OF_MODES-1:0] valid_q, intl_q;
    logic [15:0]            width_q [NO_OF_MODES];
    logic [15:0]            height_q [NO_OF_MODES];
    logic [15:0]            hb_q [NO_OF_MODES];
    logic [15:0]            vb_q [NO_OF_MODES];
    logic [15:0]            hs_q [NO_OF_MODES];
    logic [15:0]            vs_q [NO_OF_MODES];
    wstate_t                wstate_q, wstate_d;
    sstate_t                sstate_q, sstate_d;
    logic [IW-1:0]          idx_q, idx_d, sel;
    logic [NO_OF_MODES-1:0] res_q, res_d, match_q, match_d;
    logic                   change_q, change_d;
    logic [15:0]            hw_q, hw_d, hh_q, hh_d;
    logic                   hi_q, hi_d, seen_q, seen_d;
    logic [7:0]             off;
    logic [4:0]             wm;
    logic [2:0]             ww;
    logic                   wr_commit, wr_hit, hit_idx;
    timing_t                cur_q;

    // Mode m, word w lives at 5 + 8m + w.
    assign off = av_address - 8'd5;
    assign wm = off[7:3];
    assign ww = off[2:0];
    assign wr_commit = wstate_q == W_IDLE && write_trigger;
    assign wr_hit = wr_commit && av_address >= 8'd5 && wm < 5'(NO_OF_MODES) && ww != 3'd7;
    assign av_write_ack = wstate_q == W_ACK;

    always_comb wstate_d = wr_commit ? W_ACK : W_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            valid_q <= '0;
            intl_q <= '0;
            for (int i = 0; i < NO_OF_MODES; i++) begin
                width_q[i] <= '0;
                height_q[i] <= '0;
                hb_q[i] <= '0;
                vb_q[i] <= '0;
                hs_q[i] <= '0;
                vs_q[i] <= '0;
            end
        end else begin
            wstate_q <= wstate_d;
            if (wr_hit) begin
                case (ww)
                    3'd0: begin
                        valid_q[wm[IW-1:0]] <= av_writedata[0];
                        intl_q[wm[IW-1:0]] <= av_writedata[1];
                    end
                    3'd1: width_q[wm[IW-1:0]] <= av_writedata;
                    3'd2: height_q[wm[IW-1:0]] <= av_writedata;
                    3'd3: hb_q[wm[IW-1:0]] <= av_writedata;
                    3'd4: vb_q[wm[IW-1:0]] <= av_writedata;
                    3'd5: hs_q[wm[IW-1:0]] <= av_writedata;
                    3'd6: vs_q[wm[IW-1:0]] <= av_writedata;
                    default: ;
                endcase
            end
        end
    end

    assign hit_idx = valid_q[idx_q] && width_q[idx_q] == hw_q && height_q[idx_q] == hh_q
                     && intl_q[idx_q] == hi_q;

    // The match is committed on leaving the last index, so DONE is the cycle it becomes visible.
    always_comb begin
        sstate_d = sstate_q;
        idx_d = idx_q;
        res_d = res_q;
        match_d = match_q;
        change_d = 1'b0;
        hw_d = hw_q;
        hh_d = hh_q;
        hi_d = hi_q;
        seen_d = seen_q;
        if (hdr_valid) begin
            hw_d = hdr_width;
            hh_d = hdr_height;
            hi_d = hdr_interlaced;
            seen_d = 1'b1;
            res_d = '0;
            idx_d = '0;
            sstate_d = S_SEARCH;
        end else if (wr_hit && (sstate_q == S_SEARCH || (sstate_q == S_IDLE && seen_q && ww == 3'd0))) begin
            res_d = '0;
            idx_d = '0;
            sstate_d = S_SEARCH;
        end else if (sstate_q == S_SEARCH) begin
            if (res_q == '0 && hit_idx) res_d[idx_q] = 1'b1;
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(NO_OF_MODES - 1)) begin
                idx_d = '0;
                sstate_d = S_DONE;
                match_d = res_d;
                change_d = res_d != match_q;
            end
        end else if (sstate_q == S_DONE) begin
            sstate_d = S_IDLE;
        end
    end

    always_comb begin
        sel = '0;
        for (int i = NO_OF_MODES - 1; i >= 0; i--) if (match_q[i]) sel = IW'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sstate_q <= S_IDLE;
            idx_q <= '0;
            res_q <= '0;
            match_q <= '0;
            change_q <= 1'b0;
            hw_q <= '0;
            hh_q <= '0;
            hi_q <= 1'b0;
            seen_q <= 1'b0;
            cur_q <= '0;
        end else begin
            sstate_q <= sstate_d;
            idx_q <= idx_d;
            res_q <= res_d;
            match_q <= match_d;
            change_q <= change_d;
            hw_q <= hw_d;
            hh_q <= hh_d;
            hi_q <= hi_d;
            seen_q <= seen_d;
            if (frame_start) begin
                if (match_q != '0)
                    cur_q <= '{1'b1, intl_q[sel], width_q[sel], height_q[sel],
                               hb_q[sel], vb_q[sel], hs_q[sel], vs_q[sel]};
                else
                    cur_q.valid <= 1'b0;
            end
        end
    end

    assign mode_match = match_q;
    assign mode_change = change_q;
    assign cur_valid = cur_q.valid;
    assign cur_interlaced = cur_q.intl;
    assign cur_width = cur_q.w;
    assign cur_height = cur_q.h;
    assign cur_h_blank = cur_q.hb;
    assign cur_v_blank = cur_q.vb;
    assign cur_h_sync = cur_q.hs;
    assign cur_v_sync = cur_q.vs;

`ifdef ITC_MODE_READBACK_EN
    logic [15:0] rd;
    always_comb begin
        rd = '0;
        if (av_address >= 8'd5 && wm < 5'(NO_OF_MODES)) begin
            case (ww)
                3'd0: rd = {14'b0, intl_q[wm[IW-1:0]], valid_q[wm[IW-1:0]]};
                3'd1: rd = width_q[wm[IW-1:0]];
                3'd2: rd = height_q[wm[IW-1:0]];
                3'd3: rd = hb_q[wm[IW-1:0]];
                3'd4: rd = vb_q[wm[IW-1:0]];
                3'd5: rd = hs_q[wm[IW-1:0]];
                3'd6: rd = vs_q[wm[IW-1:0]];
                default: rd = '0;
            endcase
        end
    end
    assign mb_readdata = rd;
`else
    assign mb_readdata = '0;
`endif
endmodule

// File: tb/tb_itc_mode_bank.sv
// tb_itc_mode_bank: scoreboard bench for itc_mode_bank (NO_OF_MODES=2); mode_change pulses are
// checked against expected matches queued when each header is sent.
module tb_itc_mode_bank;
    logic        clk = 1'b0, rst = 1'b1, write_trigger = 1'b0;
    logic [7:0]  av_address = '0;
    logic [15:0] av_writedata = '0;
    logic        hdr_valid = 1'b0, hdr_interlaced = 1'b0, frame_start = 1'b0;
    logic [15:0] hdr_width = '0, hdr_height = '0;
    logic        av_write_ack, mode_change, cur_valid, cur_interlaced;
    logic [1:0]  mode_match;
    logic [15:0] cur_width, cur_height, cur_h_blank, cur_v_blank, cur_h_sync, cur_v_sync, mb_readdata;

    int          n_cmp = 0, n_bad = 0;
    logic [1:0]  exp_q [$];
    logic [1:0]  model_match = '0, sb_e;
    logic        m_valid [2], m_intl [2];
    logic [15:0] m_w [2], m_h [2];

    itc_mode_bank #(.NO_OF_MODES(2)) dut (
        .clk(clk), .rst(rst), .write_trigger(write_trigger), .av_address(av_address),
        .av_writedata(av_writedata), .av_write_ack(av_write_ack), .hdr_valid(hdr_valid),
        .hdr_width(hdr_width), .hdr_height(hdr_height), .hdr_interlaced(hdr_interlaced),
        .frame_start(frame_start), .mode_match(mode_match), .mode_change(mode_change),
        .cur_valid(cur_valid), .cur_interlaced(cur_interlaced), .cur_width(cur_width),
        .cur_height(cur_height), .cur_h_blank(cur_h_blank), .cur_v_blank(cur_v_blank),
        .cur_h_sync(cur_h_sync), .cur_v_sync(cur_v_sync), .mb_readdata(mb_readdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    // Every mode_change pulse must correspond to a queued expected match.
    always @(negedge clk) begin
        if (!rst && mode_change) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_change: mode_match=%b with no change expected", mode_match);
            end else begin
                sb_e = exp_q.pop_front();
                if (mode_match !== sb_e) begin
                    n_bad++;
                    $display("FAIL sb_match: mode_match=%b expected %b", mode_match, sb_e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] model_search(input logic [15:0] w, input logic [15:0] h, input logic i);
        for (int m = 0; m < 2; m++)
            if (m_valid[m] && m_w[m] == w && m_h[m] == h && m_intl[m] == i) return 2'(1 << m);
        return 2'b00;
    endfunction

    function automatic void sb_expect(input logic [15:0] w, input logic [15:0] h, input logic i);
        logic [1:0] r;
        r = model_search(w, h, i);
        if (r != model_match) begin
            exp_q.push_back(r);
            model_match = r;
        end
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [15:0] d);
        int o;
        if (a >= 8'd5) begin
            o = int'(a) - 5;
            if (o / 8 < 2) begin
                if (o % 8 == 0) begin
                    m_valid[o/8] = d[0];
                    m_intl[o/8] = d[1];
                end else if (o % 8 == 1) m_w[o/8] = d;
                else if (o % 8 == 2) m_h[o/8] = d;
            end
        end
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        write_trigger = 1'b1;
        av_address = a;
        av_writedata = d;
        cyc();
        write_trigger = 1'b0;
        model_write(a, d);
        cyc();
    endtask

    task automatic send_hdr(input logic [15:0] w, input logic [15:0] h, input logic i);
        hdr_valid = 1'b1;
        hdr_width = w;
        hdr_height = h;
        hdr_interlaced = i;
        sb_expect(w, h, i);
        cyc();
        hdr_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0;
            m_intl[m] = 1'b0;
            m_w[m] = '0;
            m_h[m] = '0;
        end
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        n_cmp++;
        if ({mode_match, mode_change, av_write_ack, cur_valid, cur_interlaced} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {mode_match, mode_change, av_write_ack, cur_valid, cur_interlaced});
        end
        n_cmp++;
        if ({cur_width, cur_height, cur_h_blank, cur_v_blank, cur_h_sync, cur_v_sync, mb_readdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: cur_width=%0d cur_height=%0d mb_readdata=%0d expected 0",
                     cur_width, cur_height, mb_readdata);
        end
    endtask

    task automatic test_write();
        write_trigger = 1'b1;
        av_address = 8'd5;
        av_writedata = 16'h0003;
        n_cmp++;
        if (av_write_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_early: av_write_ack=%b expected 0", av_write_ack);
        end
        cyc();
        write_trigger = 1'b0;
        model_write(8'd5, 16'h0003);
        n_cmp++;
        if (av_write_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_t1: av_write_ack=%b expected 1", av_write_ack);
        end
        cyc();
        n_cmp++;
        if (av_write_ack !== 1'b0 || mode_match !== 2'b00 || cur_valid !== 1'b0 || cur_width !== 16'd0) begin
            n_bad++;
            $display("FAIL ack_once: ack=%b mode_match=%b cur_valid=%b cur_width=%0d expected 0/00/0/0",
                     av_write_ack, mode_match, cur_valid, cur_width);
        end
    endtask

    task automatic test_match();
        do_write(8'd6, 16'd1280);
`ifdef ITC_MODE_READBACK_EN
        av_address = 8'd6;
        #1;
        n_cmp++;
        if (mb_readdata !== 16'd1280) begin
            n_bad++;
            $display("FAIL readback_w1: mb_readdata=%0d expected 1280", mb_readdata);
        end
        av_address = 8'd5;
        #1;
        n_cmp++;
        if (mb_readdata !== 16'h0003) begin
            n_bad++;
            $display("FAIL readback_w0: mb_readdata=%h expected 0003", mb_readdata);
        end
`else
        av_address = 8'd6;
        #1;
        n_cmp++;
        if (mb_readdata !== 16'd0) begin
            n_bad++;
            $display("FAIL readback_off: mb_readdata=%0d expected 0", mb_readdata);
        end
`endif
        do_write(8'd13, 16'h0001);
        do_write(8'd14, 16'd1280);
        do_write(8'd15, 16'd720);
        do_write(8'd16, 16'd370);
        do_write(8'd17, 16'd30);
        do_write(8'd18, 16'd40);
        do_write(8'd19, 16'd5);
        send_hdr(16'd1280, 16'd720, 1'b0);
        n_cmp++;
        if (mode_change !== 1'b0) begin
            n_bad++;
            $display("FAIL match_t1: mode_change=%b expected 0", mode_change);
        end
        cyc();
        n_cmp++;
        if (mode_change !== 1'b0 || mode_match !== 2'b00) begin
            n_bad++;
            $display("FAIL match_t2: mode_change=%b mode_match=%b expected 0/00", mode_change, mode_match);
        end
        cyc();
        n_cmp++;
        if (mode_change !== 1'b1 || mode_match !== 2'b10) begin
            n_bad++;
            $display("FAIL match_t3: mode_change=%b mode_match=%b expected 1/10", mode_change, mode_match);
        end
        cyc();
        n_cmp++;
        if (mode_change !== 1'b0 || cur_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL match_t4: mode_change=%b cur_valid=%b expected 0/0", mode_change, cur_valid);
        end
        pulse_frame();
        n_cmp++;
        if ({cur_valid, cur_interlaced, cur_width, cur_height, cur_h_blank, cur_v_blank, cur_h_sync, cur_v_sync}
            !== {1'b1, 1'b0, 16'd1280, 16'd720, 16'd370, 16'd30, 16'd40, 16'd5}) begin
            n_bad++;
            $display("FAIL shadow_load: v=%b i=%b w=%0d h=%0d hb=%0d vb=%0d hs=%0d vs=%0d expected 1 0 1280 720 370 30 40 5",
                     cur_valid, cur_interlaced, cur_width, cur_height, cur_h_blank, cur_v_blank, cur_h_sync, cur_v_sync);
        end
        do_write(8'd14, 16'd1920);
        n_cmp++;
        if (cur_width !== 16'd1280) begin
            n_bad++;
            $display("FAIL shadow_hold: cur_width=%0d expected 1280", cur_width);
        end
        do_write(8'd14, 16'd1280);
    endtask

    task automatic test_no_match();
        send_hdr(16'd640, 16'd480, 1'b0);
        cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        n_cmp++;
        if (mode_change !== 1'b1 || mode_match !== 2'b00 || cur_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL nomatch_done: mode_change=%b mode_match=%b cur_valid=%b expected 1/00/1",
                     mode_change, mode_match, cur_valid);
        end
        pulse_frame();
        n_cmp++;
        if (cur_valid !== 1'b0 || cur_width !== 16'd1280) begin
            n_bad++;
            $display("FAIL nomatch_shadow: cur_valid=%b cur_width=%0d expected 0/1280", cur_valid, cur_width);
        end
    endtask

    task automatic test_restart();
        do_write(8'd5, 16'h0001);
        do_write(8'd7, 16'd720);
        repeat (4) cyc();
        hdr_valid = 1'b1;
        hdr_width = 16'd1280;
        hdr_height = 16'd720;
        hdr_interlaced = 1'b0;
        cyc();
        hdr_valid = 1'b0;
        write_trigger = 1'b1;
        av_address = 8'd5;
        av_writedata = 16'h0000;
        cyc();
        write_trigger = 1'b0;
        model_write(8'd5, 16'h0000);
        sb_expect(16'd1280, 16'd720, 1'b0);
        n_cmp++;
        if (av_write_ack !== 1'b1 || mode_change !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_ack: ack=%b mode_change=%b expected 1/0", av_write_ack, mode_change);
        end
        cyc();
        n_cmp++;
        if (mode_change !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_early: mode_change=%b expected 0", mode_change);
        end
        cyc();
        n_cmp++;
        if (mode_change !== 1'b1 || mode_match !== 2'b10) begin
            n_bad++;
            $display("FAIL restart_result: mode_change=%b mode_match=%b expected 1/10", mode_change, mode_match);
        end
        repeat (3) cyc();
    endtask

    task automatic test_repeat();
        send_hdr(16'd1280, 16'd720, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (mode_change !== 1'b0 || mode_match !== 2'b10) begin
                n_bad++;
                $display("FAIL repeat_quiet[%0d]: mode_change=%b mode_match=%b expected 0/10", k, mode_change, mode_match);
            end
            cyc();
        end
        write_trigger = 1'b1;
        av_address = 8'd250;
        av_writedata = 16'hFFFF;
        cyc();
        write_trigger = 1'b0;
        n_cmp++;
        if (av_write_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_ack: av_write_ack=%b expected 1", av_write_ack);
        end
        cyc();
`ifdef ITC_MODE_READBACK_EN
        av_address = 8'd14;
        #1;
        n_cmp++;
        if (mb_readdata !== 16'd1280) begin
            n_bad++;
            $display("FAIL oor_intact: mb_readdata=%0d expected 1280", mb_readdata);
        end
        av_address = 8'd250;
        #1;
        n_cmp++;
        if (mb_readdata !== 16'd0) begin
            n_bad++;
            $display("FAIL oor_read: mb_readdata=%0d expected 0", mb_readdata);
        end
`endif
        pulse_frame();
        n_cmp++;
        if (cur_valid !== 1'b1 || cur_width !== 16'd1280 || cur_height !== 16'd720) begin
            n_bad++;
            $display("FAIL oor_shadow: cur_valid=%b w=%0d h=%0d expected 1/1280/720", cur_valid, cur_width, cur_height);
        end
        repeat (4) cyc();
    endtask

    initial begin
        test_reset();
        test_write();
        test_match();
        test_no_match();
        test_restart();
        test_repeat();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expected mode changes never seen, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/itc_mode_bank.md
# itc_mode_bank

Mode register bank for the clocked-video output path: stores `NO_OF_MODES` sets of video timing parameters written over the Avalon-MM control port, matches each incoming ImageStream frame header against the valid modes, and presents the selected mode's timing to the output timing generator. Sits directly downstream of the IS2Vid control block. It consumes that block's `write_trigger` and returns `av_write_ack`, `mode_change` and `mode_match` to it.

## Interface
- `NO_OF_MODES`, 2: number of mode register sets, 1..31.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `write_trigger`  in  1  write request for addresses >= 5, held until acknowledged.
- `av_address`  in  8  Avalon word address.
- `av_writedata`  in  16  write data.
- `av_write_ack`  out  1  one-cycle write acknowledge.
- `hdr_valid`  in  1  one-cycle strobe; header fields are valid.
- `hdr_width`  in  16  incoming frame width.
- `hdr_height`  in  16  incoming frame height.
- `hdr_interlaced`  in  1  incoming frame is interlaced.
- `frame_start`  in  1  strobe from the timing generator; safe point to load new timing.
- `mode_match`  out  NO_OF_MODES  one-hot index of the matched mode; 0 when nothing matches.
- `mode_change`  out  1  one-cycle pulse when `mode_match` changes.
- `cur_valid`, `cur_interlaced`  out  1 each  state of the active timing set.
- `cur_width`, `cur_height`, `cur_h_blank`, `cur_v_blank`, `cur_h_sync`, `cur_v_sync`  out  16 each  active timing parameters.
- `mb_readdata`  out  16  register readback (see Configuration).

## Operation
- **Address map.** Mode m, word w is at address 5 + 8m + w.
  - w0: bit0 = valid, bit1 = interlaced.
  - w1: width. w2: height. w3: h_blank. w4: v_blank. w5: h_sync. w6: v_sync.
  - w7: reserved. Writes to w7 are acknowledged and discarded.
  - Addresses >= 5 + 8·NO_OF_MODES are acknowledged; no register changes.
- **Write FSM** (IDLE, ACK).
  - IDLE with `write_trigger`=1: the register is written on that clock edge, and the FSM moves to ACK.
  - ACK: `av_write_ack`=1, then the FSM returns to IDLE unconditionally.
  - If `write_trigger` is still high in the cycle after ACK, it is a new write.
- **Search FSM** (IDLE, SEARCH, DONE).
  - `hdr_valid` latches width, height and interlaced, sets `hdr_seen`, clears the result, and enters SEARCH at index 0.
  - SEARCH compares one mode per cycle. A mode matches when valid=1 and its width, height and interlaced fields all equal the latched header.
  - Only the lowest-index match is kept.
  - After index NO_OF_MODES-1 the FSM enters DONE. If the result differs from `mode_match`, `mode_match` is loaded and `mode_change` pulses. Then the FSM returns to IDLE.
- **Restarts.**
  - `hdr_valid` in any state restarts the search from index 0 with the new header.
  - A committed write to any mode register restarts an in-progress search from index 0 with the same header.
  - A write to any w0 while the search FSM is IDLE and `hdr_seen`=1 starts a search with the last header.
- **Shadow load.** On `frame_start`:
  - if `mode_match`≠0: `cur_*` load from the matched mode and `cur_valid`=1;
  - otherwise `cur_valid`=0 and the other `cur_*` outputs hold.
  - Register writes never alter `cur_*` between `frame_start` strobes.

## Timing
- Reset value of every output is 0. Reset also clears all mode registers, `hdr_seen`, and both FSMs to IDLE.
- A reset in the middle of a write or search abandons it; no ack is issued.
- Write: `write_trigger` sampled at cycle T, `av_write_ack`=1 at T+1. A write into mode m is visible to a comparison from T+1.
- Search: `hdr_valid` at T. Indices are compared at T+1..T+NO_OF_MODES. `mode_match` and `mode_change` update at T+NO_OF_MODES+1.
- `frame_start` coincident with the DONE update uses the old `mode_match`. The new match applies at the next `frame_start`.
- `hdr_valid` coincident with a write commit: the header restart wins, and the write still completes.

## Configuration
- `ITC_MODE_READBACK_EN` defined:
  - `mb_readdata` returns, combinationally, the register addressed by `av_address`.
  - w0 reads as {14'b0, interlaced, valid}.
  - Unmapped addresses and addresses < 5 read 0.
- Not defined: `mb_readdata` is tied to 0 and the readback multiplexer is omitted.

## Test plan
- Reset, then one write: write 0x0003 to address 5 -> `av_write_ack` high exactly one cycle later; all `cur_*` and `mode_match` stay 0.
- Match: program mode 1 (valid, 1280×720, progressive); send `hdr_valid` with 1280×720 -> `mode_match`=2'b10 and `mode_change` pulse at T+3. At the next `frame_start`: `cur_width`=1280, `cur_valid`=1.
- No match: send a 640×480 header -> `mode_match`=0, one `mode_change` pulse; next `frame_start` -> `cur_valid`=0.
- Restart on write: write mode 0 w0=0 during the SEARCH cycle at index 0 -> search restarts; result is taken from the updated registers; exactly one `mode_change`.
- Repeat header: the same header twice -> no second `mode_change`. A write to address 250 with NO_OF_MODES=2 -> acknowledged, no register changes.
- With `ITC_MODE_READBACK_EN`: read address 6 after writing 1280 -> `mb_readdata`=1280. Without the macro -> `mb_readdata`=0.
